// File: rtl/disp_scan_ctrl_if.sv
// rtl/disp_scan_ctrl_if.sv - write-request bus for the display digit buffer
// Two independent requesters, each with a valid/ready handshake carrying a
// digit index and a BCD value.
//   master : requester side (drives valid/idx/data, receives ready)
//   slave  : scan controller side (receives valid/idx/data, drives ready)
interface disp_scan_ctrl_if;
  logic       req0_valid;
  logic [2:0] req0_idx;
  logic [3:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [2:0] req1_idx;
  logic [3:0] req1_data;
  logic       req1_ready;

  modport master (
    output req0_valid, req0_idx, req0_data, req1_valid, req1_idx, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_idx, req0_data, req1_valid, req1_idx, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - 8-digit multiplexed display scanner with buffer write arbiter
// Ports:
//   clk    : system clock, rising edge
//   rst    : asynchronous reset, active-high
//   en     : display enable
//   req    : two-requester write bus (slave side), ready is combinational
//   ds     : active-low one-hot digit strobes, 8'hFF = all off
//   sel    : index of the current slot
//   digit  : buffer contents for sel, feeds the BCD-to-7-segment decoder
//   blank  : 1 = segment drivers must be off
module disp_scan_ctrl #(
  parameter int SCAN_DIV    = 1000,
  parameter int BLANK       = 4,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  disp_scan_ctrl_if.slave        req,
  output logic [7:0]             ds,
  output logic [2:0]             sel,
  output logic [3:0]             digit,
  output logic                   blank
);

  localparam int            CW      = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST    = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
  localparam bit            LZ      = (LZ_SUPPRESS != 0);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    sel_n;
  logic          run;       // en as seen on the previous edge; low means the next enabled edge restarts the slot
  logic          ptr;       // round-robin owner: 0 = req0, 1 = req1
  logic [3:0]    buf_q [8];
  logic [7:0]    hi_zero;   // hi_zero[i]: buf_q[i] and every higher entry are zero
  logic          show;
  logic          r0;
  logic          r1;
  logic          g1;
  logic          wr_en;
  logic [2:0]    wr_idx;
  logic [3:0]    wr_data;

  // Arbiter: the pointer only matters when both requesters contend.
  always_comb begin
    r0 = 1'b0;
    r1 = 1'b0;
    if (!rst) begin
      if (req.req0_valid && req.req1_valid) begin
        r0 = !ptr;
        r1 = ptr;
      end else begin
        r0 = req.req0_valid;
        r1 = req.req1_valid;
      end
    end
  end

  assign req.req0_ready = r0;
  assign req.req1_ready = r1;
  assign g1      = req.req1_valid && r1;
  assign wr_en   = (req.req0_valid && r0) || g1;
  assign wr_idx  = g1 ? req.req1_idx  : req.req0_idx;
  assign wr_data = g1 ? req.req1_data : req.req0_data;

  always_comb begin
    hi_zero[7] = (buf_q[7] == 4'd0);
    for (int i = 6; i >= 0; i--) begin
      hi_zero[i] = (buf_q[i] == 4'd0) && hi_zero[i+1];
    end
  end

  // Next slot position; the registered outputs are derived from it so that
  // ds/sel/digit/blank all describe the same slot cycle.
  always_comb begin
    cnt_n = cnt;
    sel_n = sel;
    if (!en || !run) begin
      cnt_n = '0;
    end else if (cnt == LAST) begin
      cnt_n = '0;
      sel_n = sel - 3'd1;   // 0 wraps naturally to 7
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end

  assign show = en && !(cnt_n < BLANK_C) && !(LZ && (sel_n != 3'd0) && hi_zero[sel_n]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      sel   <= 3'd7;
      run   <= 1'b0;
      ptr   <= 1'b0;
      ds    <= 8'hFF;
      digit <= 4'd0;
      blank <= 1'b1;
      for (int i = 0; i < 8; i++) begin
        buf_q[i] <= 4'd0;
      end
    end else begin
      cnt   <= cnt_n;
      sel   <= sel_n;
      run   <= en;
      ds    <= show ? ~(8'd1 << sel_n) : 8'hFF;
      blank <= !show;
      digit <= buf_q[sel_n];
      if (wr_en) begin
        buf_q[wr_idx] <= wr_data;
      end
      if (req.req0_valid && req.req1_valid) begin
        ptr <= !ptr;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - scoreboard testbench for disp_scan_ctrl
module tb_disp_scan_ctrl;
  localparam int SD = 4;
  localparam int BL = 1;
  localparam int LZ = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] ds;
  logic [2:0] sel;
  logic [3:0] digit;
  logic       blank;

  disp_scan_ctrl_if rq ();

  disp_scan_ctrl #(.SCAN_DIV(SD), .BLANK(BL), .LZ_SUPPRESS(LZ)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .req   (rq.slave),
    .ds    (ds),
    .sel   (sel),
    .digit (digit),
    .blank (blank)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] ds;
    logic [2:0] sel;
    logic [3:0] digit;
    logic       blank;
  } exp_t;

  exp_t expq[$];

  // Reference model: slot position is derived from elapsed enabled cycles.
  int mbuf[8] = '{default: 0};
  bit mrun    = 0;
  int mt      = 0;
  int mstart  = 7;
  int msel    = 7;
  bit mptr    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin : model
    exp_t       e;
    int         ph;
    bit         supp;
    logic [7:0] one_hot;
    if (rst) begin
      foreach (mbuf[i]) mbuf[i] = 0;
      mrun = 0; mt = 0; mstart = 7; msel = 7; mptr = 0;
      e = '{8'hFF, 3'd7, 4'd0, 1'b1};
    end else begin
      ph = 0;
      if (en) begin
        if (!mrun) begin
          mt = 0;
          mstart = msel;
        end else begin
          mt++;
        end
        msel = (((mstart - mt / SD) % 8) + 8) % 8;
        ph = mt % SD;
      end
      mrun = en;
      supp = (LZ != 0) && (msel > 0);
      for (int j = 0; j < 8; j++) begin
        if (j >= msel && mbuf[j] != 0) supp = 0;
      end
      e.sel   = 3'(msel);
      e.digit = 4'(mbuf[msel]);
      if (!en || ph < BL || supp) begin
        e.ds = 8'hFF;
        e.blank = 1'b1;
      end else begin
        one_hot = 8'd1 << msel;
        e.ds = ~one_hot;
        e.blank = 1'b0;
      end
      if (rq.req0_valid && rq.req1_valid) begin
        if (!mptr) mbuf[rq.req0_idx] = rq.req0_data;
        else       mbuf[rq.req1_idx] = rq.req1_data;
        mptr = !mptr;
      end else if (rq.req0_valid) begin
        mbuf[rq.req0_idx] = rq.req0_data;
      end else if (rq.req1_valid) begin
        mbuf[rq.req1_idx] = rq.req1_data;
      end
    end
    expq.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   x0;
    bit   x1;
    if (expq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL queue_empty actual=0 required=1 at %0t", $time);
    end else begin
      e = expq.pop_front();
      if (rst) begin
        check("rst_ds", ds, 8'hFF);
        check("rst_sel", sel, 3'd7);
        check("rst_digit", digit, 4'd0);
        check("rst_blank", blank, 1'b1);
        check("rst_ready0", rq.req0_ready, 1'b0);
        check("rst_ready1", rq.req1_ready, 1'b0);
      end else begin
        check("ds", ds, e.ds);
        check("sel", sel, e.sel);
        check("digit", digit, e.digit);
        check("blank", blank, e.blank);
        if (rq.req0_valid && rq.req1_valid) begin
          x0 = !mptr;
          x1 = mptr;
        end else begin
          x0 = rq.req0_valid;
          x1 = rq.req1_valid;
        end
        check("ready0", rq.req0_ready, x0);
        check("ready1", rq.req1_ready, x1);
        check("one_ready", rq.req0_ready && rq.req1_ready, 1'b0);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write(input int p, input int idx, input int data);
    bit got;
    int n;
    got = 0;
    n = 0;
    if (p == 0) begin
      rq.req0_valid = 1'b1; rq.req0_idx = 3'(idx); rq.req0_data = 4'(data);
    end else begin
      rq.req1_valid = 1'b1; rq.req1_idx = 3'(idx); rq.req1_data = 4'(data);
    end
    while (!got && n < 50) begin
      @(negedge clk);
      got = (p == 0) ? rq.req0_ready : rq.req1_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (p == 0) rq.req0_valid = 1'b0;
    else        rq.req1_valid = 1'b0;
    check("write_granted", got, 1'b1);
  endtask

  task automatic wait_shown(input int s);
    int n;
    n = 0;
    while (!(sel == 3'(s) && blank == 1'b0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_shown", (n < 200), 1'b1);
  endtask

  initial begin : stim
    int  gl[$];
    int  k0;
    bit  g0;
    bit  g1;
    int  arb_exp[3];
    int  lz_vals[8];
    rq.req0_valid = 0; rq.req0_idx = 0; rq.req0_data = 0;
    rq.req1_valid = 0; rq.req1_idx = 0; rq.req1_data = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cycles(2);
    en = 1'b1;
    cycles(40);

    // Scan order with buffer 7..0 = 8..1
    for (int i = 0; i < 8; i++) write(0, i, i + 1);
    cycles(40);

    // Enable drop while slot 4 is lit
    wait_shown(4);
    en = 1'b0;
    cycles(3);
    en = 1'b1;
    cycles(10);

    // Live update of the displayed digit
    wait_shown(2);
    write(1, 2, 9);
    cycles(6);

    // Contention: expect req0, req1, req0
    arb_exp = '{0, 1, 0};
    k0 = 0;
    rq.req0_valid = 1; rq.req0_idx = 5; rq.req0_data = 3;
    rq.req1_valid = 1; rq.req1_idx = 6; rq.req1_data = 4;
    for (int c = 0; c < 10 && (rq.req0_valid || rq.req1_valid); c++) begin
      @(negedge clk);
      g0 = rq.req0_ready;
      g1 = rq.req1_ready;
      @(posedge clk);
      #1;
      if (g0) begin
        gl.push_back(0);
        if (k0 == 0) begin
          rq.req0_idx = 4; rq.req0_data = 2; k0 = 1;
        end else begin
          rq.req0_valid = 0;
        end
      end
      if (g1) begin
        gl.push_back(1);
        rq.req1_valid = 0;
      end
    end
    rq.req0_valid = 0;
    rq.req1_valid = 0;
    check("arb_count", gl.size(), 3);
    for (int i = 0; i < 3; i++) check("arb_order", (i < gl.size()) ? gl[i] : -1, arb_exp[i]);
    cycles(40);

    // Leading zeros: digits 7..0 = 0,0,0,0,0,1,0,5
    lz_vals = '{5, 0, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) write(i % 2, i, lz_vals[i]);
    cycles(40);

    // Randomised traffic and enable toggling
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      g0 = rq.req0_ready;
      g1 = rq.req1_ready;
      @(posedge clk);
      #1;
      if (rq.req0_valid && g0) rq.req0_valid = 0;
      if (rq.req1_valid && g1) rq.req1_valid = 0;
      if (!rq.req0_valid && $urandom_range(0, 2) == 0) begin
        rq.req0_valid = 1;
        rq.req0_idx   = 3'($urandom);
        rq.req0_data  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      end
      if (!rq.req1_valid && $urandom_range(0, 2) == 0) begin
        rq.req1_valid = 1;
        rq.req1_idx   = 3'($urandom);
        rq.req1_data  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      end
      if ($urandom_range(0, 99) == 0) en = ~en;
    end
    for (int c = 0; c < 20 && (rq.req0_valid || rq.req1_valid); c++) begin
      @(negedge clk);
      g0 = rq.req0_ready;
      g1 = rq.req1_ready;
      @(posedge clk);
      #1;
      if (g0) rq.req0_valid = 0;
      if (g1) rq.req1_valid = 0;
    end
    check("drain", rq.req0_valid || rq.req1_valid, 1'b0);
    rq.req0_valid = 0;
    rq.req1_valid = 0;
    en = 1'b1;

    // Asynchronous reset mid-scan with a non-zero buffer
    write(0, 0, 3);
    write(0, 7, 6);
    cycles(7);
    #2 rst = 1'b1;
    rq.req0_valid = 1; rq.req0_idx = 1; rq.req0_data = 7;
    #1;
    check("async_ds", ds, 8'hFF);
    check("async_sel", sel, 3'd7);
    check("async_digit", digit, 4'd0);
    check("async_blank", blank, 1'b1);
    check("async_ready0", rq.req0_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rq.req0_valid = 0;
    cycles(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Scan controller and write arbiter for the 8-digit multiplexed 7-segment display. Owns an 8-entry BCD digit buffer and sequences the active-low digit strobes (ds) with a programmable slot period and an anti-ghosting blank window. Arbitrates buffer writes from two requesters with a valid/ready handshake. Output digit code feeds the existing BCD-to-7-segment decoder.

Parameters:
SCAN_DIV, 1000, clk cycles per digit slot; legal range >= 2 and > BLANK
BLANK, 4, cycles at the start of each slot with all strobes off; legal range >= 0
LZ_SUPPRESS, 1, 1 = blank leading zeros (digit 0 is always shown)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
en  in  1  display enable
req0_valid  in  1  requester 0 write request
req0_idx  in  3  requester 0 target digit (0 = least significant)
req0_data  in  4  requester 0 BCD value
req0_ready  out  1  requester 0 grant (combinational)
req1_valid  in  1  requester 1 write request
req1_idx  in  3  requester 1 target digit
req1_data  in  4  requester 1 BCD value
req1_ready  out  1  requester 1 grant (combinational)
ds  out  8  digit strobes, active-low one-hot; 8'hFF = all off
sel  out  3  index of current slot
digit  out  4  buffer contents for sel, to the 7-segment decoder
blank  out  1  1 = segment drivers must be off

Behaviour:
- Clocking: one clock, clk. Reset: rst is asynchronous and active-high.
- Reset values: ds=8'hFF, sel=7, digit=0, blank=1, all 8 buffer entries=0, slot counter=0, round-robin pointer=req0. While rst is high, req0_ready=req1_ready=0.
- Reset asserted mid-operation: all state returns to the reset values immediately, including the buffer.
- Slot counter: counts 0..SCAN_DIV-1 while en=1. On wrap, sel steps 7,6,5,...,0,7 (wrap from 0 to 7).
- Strobe mapping: ds=~(8'b1<<sel). sel=7 gives 8'b01111111; sel=0 gives 8'b11111110.
- Blank window: while counter < BLANK, ds=8'hFF and blank=1. Otherwise ds follows the strobe mapping and blank=0, unless suppressed.
- Leading-zero suppression (LZ_SUPPRESS=1): slot sel>0 is suppressed when buf[sel]==0 and every buf[j] with j>sel is 0. A suppressed slot drives ds=8'hFF and blank=1 for the whole slot.
- Outputs: ds, sel, digit and blank are registered. digit = buf[sel] as sampled on the previous edge.
- Write visibility: a buffer write committed at edge N appears on digit at edge N+1 if that index is selected.
- en=0: counter held at 0, sel held, ds=8'hFF, blank=1. The buffer still accepts writes.
- en 0->1: the current sel slot restarts from counter 0, beginning with its blank window.
- Arbiter: at most one buffer write per cycle. A transfer occurs when valid && ready.
  - Only one valid: that requester gets ready=1.
  - Both valid: the pointer holder gets ready=1, and the pointer moves to the other requester after the grant.
  - Neither valid: pointer unchanged.
  - A requester must hold valid/idx/data stable until ready.
- Data: values 10..15 are stored and output unchanged; the decoder defines their rendering. Suppression compares against 0 only.

Test Plan:
- Reset: assert rst mid-scan with a non-zero buffer -> ds=8'hFF, sel=7, blank=1, digit=0 immediately. After release with en=1 and all-zero buffer, only slot 0 unblanks: ds=8'b11111110, digit=0.
- Scan order (SCAN_DIV=4, BLANK=1, LZ_SUPPRESS=0, buffer 7..0 = 8,7,6,5,4,3,2,1):
  - sel sequence 7,6,...,0,7, each held 4 cycles.
  - First cycle of each slot ds=8'hFF; next 3 cycles ds=8'b01111111 with digit=8, then ds=8'b10111111 with digit=7, and so on.
- Arbitration: req0 and req1 both valid for 3 cycles with distinct idx -> grants alternate req0, req1, req0. Buffer holds each written value. Only one ready is high per cycle.
- Leading zeros (LZ_SUPPRESS=1): buffer = 0,0,0,0,0,1,0,5 (digit 7..0) -> slots 7..3 fully blank. Slot 2 shows digit=1, slot 1 shows digit=0, slot 0 shows digit=5.
- Enable: drop en mid-slot while sel=4 -> ds=8'hFF, blank=1 next edge, sel stays 4. Raise en -> BLANK cycles off, then ds=8'b11101111 for SCAN_DIV-BLANK cycles.
- Live update: while sel=2 is displayed, req1 writes idx=2, data=9 -> digit=9 one cycle after the write edge, with no strobe glitch.
